// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the EX-stage operand forwarding logic.
//   XLEN_DEF  : default operand/result bus width
//   CNTW_DEF  : default width of each forwarding-event counter
//   fwd_src_e : operand source code (regfile / MA / WB / WB-delayed)
//   fwd_hits  : how many of the two operands selected a given source (0..2)
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned CNTW_DEF = 16;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MA  = 2'd1,
        FWD_WB  = 2'd2,
        FWD_DLY = 2'd3
    } fwd_src_e;

    function automatic logic [1:0] fwd_hits(
        input fwd_src_e sel_a,
        input fwd_src_e sel_b,
        input fwd_src_e src
    );
        return {1'b0, (sel_a == src)} + {1'b0, (sel_b == src)};
    endfunction

endpackage

// File: rtl/fwd_sel_mux.sv
// -----------------------------------------------------------------------------
// fwd_sel_mux
// Priority operand mux for one source register. Picks the MA result, the WB
// result, the delayed WB copy or the register-file value, in that priority
// order, and reports the choice as a source code.
//   hit_idex  : producer now in MA       -> FWD_MA
//   hit_idma  : producer now in WB       -> FWD_WB
//   hit_idwb  : producer retired last cy -> FWD_DLY
//   rf_data, ma_data, wb_data, dly_data : candidate values
//   op        : selected operand
//   sel       : source code of the selected operand
// -----------------------------------------------------------------------------
module fwd_sel_mux
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic            hit_idex,
    input  logic            hit_idma,
    input  logic            hit_idwb,
    input  logic [XLEN-1:0] rf_data,
    input  logic [XLEN-1:0] ma_data,
    input  logic [XLEN-1:0] wb_data,
    input  logic [XLEN-1:0] dly_data,
    output logic [XLEN-1:0] op,
    output fwd_src_e        sel
);

    // Several flags may be set at once; the youngest producer wins.
    always_comb begin
        sel = FWD_RF;
        if (hit_idex) begin
            sel = FWD_MA;
        end else if (hit_idma) begin
            sel = FWD_WB;
        end else if (hit_idwb) begin
            sel = FWD_DLY;
        end
    end

    always_comb begin
        op = rf_data;
        case (sel)
            FWD_MA:  op = ma_data;
            FWD_WB:  op = wb_data;
            FWD_DLY: op = dly_data;
            default: op = rf_data;
        endcase
    end

endmodule

// File: rtl/ex_operand_fwd.sv
// -----------------------------------------------------------------------------
// ex_operand_fwd
// EX-stage operand selector. Resolves rs1/rs2 from the regfile, MA result, WB
// result or a one-cycle-delayed WB copy using the registered hazard flags,
// freezes the resolved operands across EX stalls, and keeps saturating
// per-source forwarding-event counters.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   rst_pipe          : synchronous flush of the hold state (counters kept)
//   stall_ex          : EX frozen this cycle
//   rs1/rs2_data_ex   : regfile values latched into EX
//   hit_rsN_*_ex      : hazard flags per operand (idex > idma > idwb)
//   nohit_rsN_ex      : no-hazard flags (implied by all hits low)
//   rd_data_ma/wb     : MA result, WB write-back value
//   wbk_rd_reg_wb     : WB instruction writes a register
//   op1_ex, op2_ex    : resolved operands
//   fwd_sel1/2_ex     : source codes (0 RF, 1 MA, 2 WB, 3 WB-delayed)
//   hold_active       : operands come from the hold registers
//   fwd_cnt_ma/wb/dly : saturating forwarding-event counters
// -----------------------------------------------------------------------------
module ex_operand_fwd
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned CNTW = CNTW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rst_pipe,
    input  logic            stall_ex,
    input  logic [XLEN-1:0] rs1_data_ex,
    input  logic [XLEN-1:0] rs2_data_ex,
    input  logic            hit_rs1_idex_ex,
    input  logic            hit_rs1_idma_ex,
    input  logic            hit_rs1_idwb_ex,
    input  logic            nohit_rs1_ex,
    input  logic            hit_rs2_idex_ex,
    input  logic            hit_rs2_idma_ex,
    input  logic            hit_rs2_idwb_ex,
    input  logic            nohit_rs2_ex,
    input  logic [XLEN-1:0] rd_data_ma,
    input  logic [XLEN-1:0] rd_data_wb,
    input  logic            wbk_rd_reg_wb,
    output logic [XLEN-1:0] op1_ex,
    output logic [XLEN-1:0] op2_ex,
    output logic [1:0]      fwd_sel1_ex,
    output logic [1:0]      fwd_sel2_ex,
    output logic            hold_active,
    output logic [CNTW-1:0] fwd_cnt_ma,
    output logic [CNTW-1:0] fwd_cnt_wb,
    output logic [CNTW-1:0] fwd_cnt_dly
);

    // nohit is redundant: "all hit flags low" already selects the regfile.
    logic unused_nohit;
    assign unused_nohit = nohit_rs1_ex ^ nohit_rs2_ex;

    // ---------------------------------------------------------------- state
    logic [XLEN-1:0] wb_dly_q,   wb_dly_d;
    logic            hold_active_q, hold_active_d;
    logic [XLEN-1:0] hold_op1_q, hold_op1_d;
    logic [XLEN-1:0] hold_op2_q, hold_op2_d;
    fwd_src_e        hold_sel1_q, hold_sel1_d;
    fwd_src_e        hold_sel2_q, hold_sel2_d;
    logic [CNTW-1:0] cnt_ma_q,  cnt_ma_d;
    logic [CNTW-1:0] cnt_wb_q,  cnt_wb_d;
    logic [CNTW-1:0] cnt_dly_q, cnt_dly_d;

    // ------------------------------------------------------ live selection
    // Flags are masked during reset so the sel outputs read 0 and the
    // operands pass the regfile values straight through.
    logic            live_en;
    logic [XLEN-1:0] live_op1, live_op2;
    fwd_src_e        live_sel1, live_sel2;

    assign live_en = ~rst;

    fwd_sel_mux #(.XLEN(XLEN)) u_mux_rs1 (
        .hit_idex (hit_rs1_idex_ex & live_en),
        .hit_idma (hit_rs1_idma_ex & live_en),
        .hit_idwb (hit_rs1_idwb_ex & live_en),
        .rf_data  (rs1_data_ex),
        .ma_data  (rd_data_ma),
        .wb_data  (rd_data_wb),
        .dly_data (wb_dly_q),
        .op       (live_op1),
        .sel      (live_sel1)
    );

    fwd_sel_mux #(.XLEN(XLEN)) u_mux_rs2 (
        .hit_idex (hit_rs2_idex_ex & live_en),
        .hit_idma (hit_rs2_idma_ex & live_en),
        .hit_idwb (hit_rs2_idwb_ex & live_en),
        .rf_data  (rs2_data_ex),
        .ma_data  (rd_data_ma),
        .wb_data  (rd_data_wb),
        .dly_data (wb_dly_q),
        .op       (live_op2),
        .sel      (live_sel2)
    );

    // -------------------------------------------------------------- outputs
    assign op1_ex      = hold_active_q ? hold_op1_q  : live_op1;
    assign op2_ex      = hold_active_q ? hold_op2_q  : live_op2;
    assign fwd_sel1_ex = hold_active_q ? hold_sel1_q : live_sel1;
    assign fwd_sel2_ex = hold_active_q ? hold_sel2_q : live_sel2;
    assign hold_active = hold_active_q;
    assign fwd_cnt_ma  = cnt_ma_q;
    assign fwd_cnt_wb  = cnt_wb_q;
    assign fwd_cnt_dly = cnt_dly_q;

    // ---------------------------------------------------------- next state
    // The sum is one bit wider than the counter; its carry can only be set
    // when the true count exceeds the all-ones maximum.
    function automatic logic [CNTW-1:0] sat_add(
        input logic [CNTW-1:0] cnt,
        input logic [1:0]      inc
    );
        logic [CNTW:0] sum;
        sum = {1'b0, cnt} + (CNTW+1)'(inc);
        return sum[CNTW] ? '1 : sum[CNTW-1:0];
    endfunction

    logic cnt_en;
    assign cnt_en = ~stall_ex & ~hold_active_q;

    always_comb begin
        wb_dly_d = wb_dly_q;
        if (wbk_rd_reg_wb) begin
            wb_dly_d = rd_data_wb;
        end
    end

    // Hold is entered on the first stalled cycle and left one edge after the
    // stall drops, so the release cycle still sees the frozen operands.
    always_comb begin
        hold_active_d = hold_active_q;
        hold_op1_d    = hold_op1_q;
        hold_op2_d    = hold_op2_q;
        hold_sel1_d   = hold_sel1_q;
        hold_sel2_d   = hold_sel2_q;
        if (rst_pipe) begin
            hold_active_d = 1'b0;
            hold_op1_d    = '0;
            hold_op2_d    = '0;
            hold_sel1_d   = FWD_RF;
            hold_sel2_d   = FWD_RF;
        end else if (stall_ex && !hold_active_q) begin
            hold_active_d = 1'b1;
            hold_op1_d    = live_op1;
            hold_op2_d    = live_op2;
            hold_sel1_d   = live_sel1;
            hold_sel2_d   = live_sel2;
        end else if (!stall_ex && hold_active_q) begin
            hold_active_d = 1'b0;
        end
    end

    always_comb begin
        cnt_ma_d  = cnt_ma_q;
        cnt_wb_d  = cnt_wb_q;
        cnt_dly_d = cnt_dly_q;
        if (cnt_en) begin
            cnt_ma_d  = sat_add(cnt_ma_q,  fwd_hits(live_sel1, live_sel2, FWD_MA));
            cnt_wb_d  = sat_add(cnt_wb_q,  fwd_hits(live_sel1, live_sel2, FWD_WB));
            cnt_dly_d = sat_add(cnt_dly_q, fwd_hits(live_sel1, live_sel2, FWD_DLY));
        end
    end

    // ----------------------------------------------------------- registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_dly_q      <= '0;
            hold_active_q <= 1'b0;
            hold_op1_q    <= '0;
            hold_op2_q    <= '0;
            hold_sel1_q   <= FWD_RF;
            hold_sel2_q   <= FWD_RF;
            cnt_ma_q      <= '0;
            cnt_wb_q      <= '0;
            cnt_dly_q     <= '0;
        end else begin
            wb_dly_q      <= wb_dly_d;
            hold_active_q <= hold_active_d;
            hold_op1_q    <= hold_op1_d;
            hold_op2_q    <= hold_op2_d;
            hold_sel1_q   <= hold_sel1_d;
            hold_sel2_q   <= hold_sel2_d;
            cnt_ma_q      <= cnt_ma_d;
            cnt_wb_q      <= cnt_wb_d;
            cnt_dly_q     <= cnt_dly_d;
        end
    end

endmodule

// File: tb/tb_ex_operand_fwd.sv
// -----------------------------------------------------------------------------
// tb_ex_operand_fwd
// Directed scenarios plus a randomized run, each compared against a
// behavioural model of the forwarding rules kept in this bench.
// -----------------------------------------------------------------------------
module tb_ex_operand_fwd;

    localparam int XLEN = 32;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst, rst_pipe, stall_ex;
    logic [XLEN-1:0] rs1_data_ex, rs2_data_ex, rd_data_ma, rd_data_wb;
    logic            h1_ex, h1_ma, h1_wb, nh1, h2_ex, h2_ma, h2_wb, nh2;
    logic            wbk_rd_reg_wb;
    logic [XLEN-1:0] op1_ex, op2_ex;
    logic [1:0]      fwd_sel1_ex, fwd_sel2_ex;
    logic            hold_active;
    logic [CNTW-1:0] fwd_cnt_ma, fwd_cnt_wb, fwd_cnt_dly;

    always #5 clk = ~clk;

    ex_operand_fwd #(.XLEN(XLEN), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .rst_pipe(rst_pipe), .stall_ex(stall_ex),
        .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex),
        .hit_rs1_idex_ex(h1_ex), .hit_rs1_idma_ex(h1_ma),
        .hit_rs1_idwb_ex(h1_wb), .nohit_rs1_ex(nh1),
        .hit_rs2_idex_ex(h2_ex), .hit_rs2_idma_ex(h2_ma),
        .hit_rs2_idwb_ex(h2_wb), .nohit_rs2_ex(nh2),
        .rd_data_ma(rd_data_ma), .rd_data_wb(rd_data_wb),
        .wbk_rd_reg_wb(wbk_rd_reg_wb),
        .op1_ex(op1_ex), .op2_ex(op2_ex),
        .fwd_sel1_ex(fwd_sel1_ex), .fwd_sel2_ex(fwd_sel2_ex),
        .hold_active(hold_active),
        .fwd_cnt_ma(fwd_cnt_ma), .fwd_cnt_wb(fwd_cnt_wb), .fwd_cnt_dly(fwd_cnt_dly)
    );

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------- reference model
    logic [XLEN-1:0] m_wb_dly, m_hop1, m_hop2;
    int              m_hsel1, m_hsel2;
    bit              m_hold;
    int              m_cnt[3];          // index 0 = MA, 1 = WB, 2 = delayed
    logic [XLEN-1:0] e_op1, e_op2;
    int              e_sel1, e_sel2;

    function automatic int pick(input logic fex, input logic fma, input logic fwb);
        if (rst) return 0;
        if (fex) return 1;
        if (fma) return 2;
        if (fwb) return 3;
        return 0;
    endfunction

    function automatic logic [XLEN-1:0] src_val(input int s, input logic [XLEN-1:0] rf);
        case (s)
            1:       return rd_data_ma;
            2:       return rd_data_wb;
            3:       return m_wb_dly;
            default: return rf;
        endcase
    endfunction

    function automatic void model_reset();
        m_wb_dly = '0; m_hop1 = '0; m_hop2 = '0;
        m_hsel1 = 0; m_hsel2 = 0; m_hold = 0;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    endfunction

    function automatic void model_eval();
        int s1, s2;
        s1 = pick(h1_ex, h1_ma, h1_wb);
        s2 = pick(h2_ex, h2_ma, h2_wb);
        if (m_hold) begin
            e_op1 = m_hop1; e_op2 = m_hop2; e_sel1 = m_hsel1; e_sel2 = m_hsel2;
        end else begin
            e_op1 = src_val(s1, rs1_data_ex); e_op2 = src_val(s2, rs2_data_ex);
            e_sel1 = s1; e_sel2 = s2;
        end
    endfunction

    // Advance the model by one clock using the inputs held across the edge.
    task automatic tick();
        model_eval();
        if (rst) begin
            model_reset();
        end else begin
            if (!stall_ex && !m_hold) begin
                for (int k = 0; k < 3; k++) begin
                    m_cnt[k] += int'(e_sel1 == k + 1) + int'(e_sel2 == k + 1);
                    if (m_cnt[k] > CMAX) m_cnt[k] = CMAX;
                end
            end
            if (rst_pipe) begin
                m_hold = 0; m_hop1 = '0; m_hop2 = '0; m_hsel1 = 0; m_hsel2 = 0;
            end else if (stall_ex && !m_hold) begin
                m_hold = 1; m_hop1 = e_op1; m_hop2 = e_op2; m_hsel1 = e_sel1; m_hsel2 = e_sel2;
            end else if (!stall_ex && m_hold) begin
                m_hold = 0;
            end
            if (wbk_rd_reg_wb) m_wb_dly = rd_data_wb;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_flags();
        {h1_ex, h1_ma, h1_wb, h2_ex, h2_ma, h2_wb} = '0;
        nh1 = 1'b1; nh2 = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rst_pipe = 1'b0; stall_ex = 1'b0; wbk_rd_reg_wb = 1'b0;
        clear_flags();
        model_reset();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // ----------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b1; rst_pipe = 1'b0; stall_ex = 1'b0; wbk_rd_reg_wb = 1'b0;
        clear_flags();
        rs1_data_ex = 32'h11; rs2_data_ex = 32'h22;
        rd_data_ma = 32'h0; rd_data_wb = 32'h0;
        model_reset();
        #2;
        checks++;
        if (op1_ex !== 32'h11 || op2_ex !== 32'h22) begin
            errors++; $display("FAIL reset_ops got %h/%h exp 00000011/00000022", op1_ex, op2_ex);
        end
        checks++;
        if (fwd_sel1_ex !== 2'd0 || fwd_sel2_ex !== 2'd0 || hold_active !== 1'b0) begin
            errors++; $display("FAIL reset_sel got %0d/%0d hold %b exp 0/0 0", fwd_sel1_ex, fwd_sel2_ex, hold_active);
        end
        checks++;
        if (fwd_cnt_ma !== '0 || fwd_cnt_wb !== '0 || fwd_cnt_dly !== '0) begin
            errors++; $display("FAIL reset_cnt got %0d/%0d/%0d exp 0/0/0", fwd_cnt_ma, fwd_cnt_wb, fwd_cnt_dly);
        end
        tick();
        rst = 1'b0;
        #1;
        tick();
        checks++;
        if (op1_ex !== 32'h11 || op2_ex !== 32'h22 || fwd_sel1_ex !== 2'd0 || fwd_cnt_ma !== '0) begin
            errors++; $display("FAIL post_reset got %h/%h sel %0d cnt %0d exp 00000011/00000022 0 0",
                               op1_ex, op2_ex, fwd_sel1_ex, fwd_cnt_ma);
        end
    endtask

    task automatic test_priority();
        h1_ex = 1'b1; h1_ma = 1'b1; nh1 = 1'b0;
        rd_data_ma = 32'hAAAA0001; rd_data_wb = 32'hBBBB0002;
        #1;
        model_eval();
        checks++;
        if (op1_ex !== 32'hAAAA0001 || fwd_sel1_ex !== 2'd1) begin
            errors++; $display("FAIL prio_ma got %h sel %0d exp aaaa0001 sel 1", op1_ex, fwd_sel1_ex);
        end
        h1_ex = 1'b0;
        #1;
        checks++;
        if (op1_ex !== 32'hBBBB0002 || fwd_sel1_ex !== 2'd2) begin
            errors++; $display("FAIL prio_wb got %h sel %0d exp bbbb0002 sel 2", op1_ex, fwd_sel1_ex);
        end
        h1_ex = 1'b1;
        tick();
        clear_flags();
        #1;
        checks++;
        if (fwd_cnt_ma !== CNTW'(m_cnt[0]) || m_cnt[0] != 1) begin
            errors++; $display("FAIL prio_cnt got %0d exp 1", fwd_cnt_ma);
        end
    endtask

    task automatic test_delayed();
        wbk_rd_reg_wb = 1'b1; rd_data_wb = 32'h1234;
        tick();
        wbk_rd_reg_wb = 1'b0; rd_data_wb = 32'h9999;
        h2_wb = 1'b1; nh2 = 1'b0;
        #1;
        checks++;
        if (op2_ex !== 32'h1234 || fwd_sel2_ex !== 2'd3) begin
            errors++; $display("FAIL dly_path got %h sel %0d exp 00001234 sel 3", op2_ex, fwd_sel2_ex);
        end
        tick();
        clear_flags();
    endtask

    task automatic test_stall_hold();
        h1_ex = 1'b1; nh1 = 1'b0; rd_data_ma = 32'h55; stall_ex = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin clear_flags(); rd_data_ma = 32'h66; end
            if (c == 3) stall_ex = 1'b0;
            #1;
            model_eval();
            checks++;
            if (op1_ex !== e_op1 || fwd_sel1_ex !== 2'(e_sel1) || hold_active !== m_hold) begin
                errors++; $display("FAIL hold_c%0d got %h sel %0d hold %b exp %h sel %0d hold %b",
                                   c, op1_ex, fwd_sel1_ex, hold_active, e_op1, e_sel1, m_hold);
            end
            if (c < 4) begin
                checks++;
                if (op1_ex !== 32'h55) begin
                    errors++; $display("FAIL hold_val%0d got %h exp 00000055", c, op1_ex);
                end
            end
            checks++;
            if (fwd_cnt_ma !== CNTW'(m_cnt[0])) begin
                errors++; $display("FAIL hold_cnt%0d got %0d exp %0d", c, fwd_cnt_ma, m_cnt[0]);
            end
            tick();
        end
    endtask

    task automatic test_rst_pipe();
        h1_ex = 1'b1; nh1 = 1'b0; rd_data_ma = 32'h77; stall_ex = 1'b1;
        tick();
        h1_ex = 1'b0; h1_ma = 1'b1; rd_data_ma = 32'h88; rd_data_wb = 32'h99;
        tick();
        checks++;
        if (hold_active !== 1'b1 || op1_ex !== 32'h77) begin
            errors++; $display("FAIL pflush_pre got hold %b op %h exp 1 00000077", hold_active, op1_ex);
        end
        rst_pipe = 1'b1;
        tick();
        rst_pipe = 1'b0; stall_ex = 1'b0;
        #1;
        checks++;
        if (hold_active !== 1'b0 || op1_ex !== 32'h99 || fwd_sel1_ex !== 2'd2) begin
            errors++; $display("FAIL pflush_live got hold %b op %h sel %0d exp 0 00000099 2",
                               hold_active, op1_ex, fwd_sel1_ex);
        end
        checks++;
        if (fwd_cnt_ma !== CNTW'(m_cnt[0]) || fwd_cnt_wb !== CNTW'(m_cnt[1]) || fwd_cnt_dly !== CNTW'(m_cnt[2])) begin
            errors++; $display("FAIL pflush_cnt got %0d/%0d/%0d exp %0d/%0d/%0d",
                               fwd_cnt_ma, fwd_cnt_wb, fwd_cnt_dly, m_cnt[0], m_cnt[1], m_cnt[2]);
        end
        tick();
        clear_flags();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            {h1_ex, h1_ma, h1_wb, h2_ex, h2_ma, h2_wb} = 6'($urandom) & 6'($urandom);
            nh1 = ~(h1_ex | h1_ma | h1_wb);
            nh2 = ~(h2_ex | h2_ma | h2_wb);
            stall_ex      = ($urandom_range(0, 9) < 3);
            rst_pipe      = ($urandom_range(0, 19) == 0);
            wbk_rd_reg_wb = $urandom_range(0, 1);
            rs1_data_ex = $urandom; rs2_data_ex = $urandom;
            rd_data_ma  = $urandom; rd_data_wb  = $urandom;
            #1;
            model_eval();
            checks++;
            if (op1_ex !== e_op1 || op2_ex !== e_op2 || fwd_sel1_ex !== 2'(e_sel1) ||
                fwd_sel2_ex !== 2'(e_sel2) || hold_active !== m_hold) begin
                errors++; $display("FAIL rand_ops c%0d got %h %h %0d %0d %b exp %h %h %0d %0d %b", c,
                                   op1_ex, op2_ex, fwd_sel1_ex, fwd_sel2_ex, hold_active,
                                   e_op1, e_op2, e_sel1, e_sel2, m_hold);
            end
            checks++;
            if (fwd_cnt_ma !== CNTW'(m_cnt[0]) || fwd_cnt_wb !== CNTW'(m_cnt[1]) || fwd_cnt_dly !== CNTW'(m_cnt[2])) begin
                errors++; $display("FAIL rand_cnt c%0d got %0d/%0d/%0d exp %0d/%0d/%0d", c,
                                   fwd_cnt_ma, fwd_cnt_wb, fwd_cnt_dly, m_cnt[0], m_cnt[1], m_cnt[2]);
            end
            // Restart occasionally so the narrow counters are exercised below saturation.
            if (c % 100 == 99) do_reset(); else tick();
        end
        rst_pipe = 1'b0; stall_ex = 1'b0; wbk_rd_reg_wb = 1'b0;
        clear_flags();
    endtask

    task automatic test_saturation();
        do_reset();
        h1_ma = 1'b1; h2_ma = 1'b1; nh1 = 1'b0; nh2 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (fwd_cnt_wb !== CNTW'(m_cnt[1])) begin
                errors++; $display("FAIL sat_cnt c%0d got %0d exp %0d", c, fwd_cnt_wb, m_cnt[1]);
            end
            tick();
        end
        checks++;
        if (fwd_cnt_wb !== 4'd15) begin
            errors++; $display("FAIL sat_final got %0d exp 15", fwd_cnt_wb);
        end
        #2;
        rs1_data_ex = '0; rs2_data_ex = '0;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (op1_ex !== '0 || op2_ex !== '0 || fwd_sel1_ex !== 2'd0 || fwd_sel2_ex !== 2'd0 ||
            hold_active !== 1'b0 || fwd_cnt_wb !== '0 || fwd_cnt_ma !== '0 || fwd_cnt_dly !== '0) begin
            errors++; $display("FAIL async_rst got %h %h %0d %0d %b %0d exp all zero",
                               op1_ex, op2_ex, fwd_sel1_ex, fwd_sel2_ex, hold_active, fwd_cnt_wb);
        end
        tick();
        rst = 1'b0;
        clear_flags();
    endtask

    initial begin
        rst = 1'b1; rst_pipe = 1'b0; stall_ex = 1'b0; wbk_rd_reg_wb = 1'b0;
        rs1_data_ex = '0; rs2_data_ex = '0; rd_data_ma = '0; rd_data_wb = '0;
        clear_flags();
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_priority();
        test_delayed();
        test_stall_hold();
        test_rst_pipe();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
